// File: rtl/mem_write_tracer.sv
// Snoops the data-memory write port and records {addr, data, cycle stamp} per write in a FWFT trace buffer.
// Stops capture on a halt-address write or a cycle timeout. Optional address window: define TRACE_FILTER_EN.
module mem_write_tracer #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DEPTH          = 16,
  parameter int                    CYCLE_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = 32'hFFFF_FFFC,
  parameter int                    TIMEOUT_CYCLES = 100000,
  parameter logic [ADDR_WIDTH-1:0] FILTER_LO      = '0,
  parameter logic [ADDR_WIDTH-1:0] FILTER_HI      = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_wen,
  input  logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_din,
  input  logic                     trace_rd_en,
  output logic                     trace_valid,
  output logic [ADDR_WIDTH-1:0]    trace_addr,
  output logic [DATA_WIDTH-1:0]    trace_data,
  output logic [CYCLE_WIDTH-1:0]   trace_cycle,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic                     halted,
  output logic                     timeout,
  output logic [CYCLE_WIDTH-1:0]   cycle_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FULL_COUNT   = CNT_W'(DEPTH);
  localparam bit                     TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);
  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LAST = CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  data;
    logic [CYCLE_WIDTH-1:0] cycle;
  } entry_t;

  state_t                 state, state_nxt;
  entry_t                 mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CYCLE_WIDTH-1:0] cyc;

  logic is_halt_addr, eligible, full, push, pop, drop;

  assign is_halt_addr = (mem_addr == HALT_ADDR);

`ifdef TRACE_FILTER_EN
  // The halt write must always reach the buffer, even outside the traced window.
  logic in_window;
  assign in_window = (mem_addr >= FILTER_LO) && (mem_addr <= FILTER_HI);
  assign eligible  = mem_wen && (state == ST_RUN) && (in_window || is_halt_addr);
`else
  logic [2*ADDR_WIDTH-1:0] unused_filter;
  assign unused_filter = {FILTER_LO, FILTER_HI};
  assign eligible      = mem_wen && (state == ST_RUN);
`endif

  assign full = (count == FULL_COUNT);
  assign pop  = trace_rd_en && (count != '0);
  // A pop on the same edge frees the slot, so a full buffer still accepts the write.
  assign push = eligible && (!full || pop);
  assign drop = eligible && full && !pop;

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN) begin
      if (eligible && is_halt_addr)
        state_nxt = ST_HALTED;
      else if (TIMEOUT_ON && (cyc == TIMEOUT_LAST))
        state_nxt = ST_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      cyc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN)
        cyc <= cyc + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: mem_addr, data: mem_din, cycle: cyc};
  end

  entry_t head;
  assign head        = mem[rd_ptr];
  assign trace_valid = (count != '0);
  assign trace_addr  = trace_valid ? head.addr  : '0;
  assign trace_data  = trace_valid ? head.data  : '0;
  assign trace_cycle = trace_valid ? head.cycle : '0;
  assign trace_count = count;
  assign halted      = (state == ST_HALTED);
  assign timeout     = (state == ST_TIMEOUT);
  assign cycle_count = cyc;

endmodule

// File: tb/tb_mem_write_tracer.sv
// Directed bench for mem_write_tracer: capture, overflow, full push+pop, halt, timeout, filter and async reset.
module tb_mem_write_tracer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        mem_wen;
  logic [31:0] mem_addr, mem_din;
  logic        trace_rd_en;

  logic        a_valid, a_ovf, a_halted, a_timeout;
  logic [31:0] a_addr, a_data, a_cycle, a_cc;
  logic [2:0]  a_count;
  logic [15:0] a_drop;

  logic        b_valid, b_ovf, b_halted, b_timeout;
  logic [31:0] b_addr, b_data, b_cycle, b_cc;
  logic [2:0]  b_count;
  logic [15:0] b_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_write_tracer #(
    .DEPTH(4), .TIMEOUT_CYCLES(0), .FILTER_LO(32'h100), .FILTER_HI(32'h1FF)
  ) dut_a (
    .clk(clk), .reset(rst_a), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .trace_rd_en(trace_rd_en), .trace_valid(a_valid), .trace_addr(a_addr), .trace_data(a_data),
    .trace_cycle(a_cycle), .trace_count(a_count), .overflow(a_ovf), .drop_count(a_drop),
    .halted(a_halted), .timeout(a_timeout), .cycle_count(a_cc)
  );

  mem_write_tracer #(
    .DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .reset(rst_b), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .trace_rd_en(trace_rd_en), .trace_valid(b_valid), .trace_addr(b_addr), .trace_data(b_data),
    .trace_cycle(b_cycle), .trace_count(b_count), .overflow(b_ovf), .drop_count(b_drop),
    .halted(b_halted), .timeout(b_timeout), .cycle_count(b_cc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_wen  = 1'b1;
    mem_addr = addr;
    mem_din  = data;
    tick(1);
    mem_wen  = 1'b0;
  endtask

  task automatic pop();
    trace_rd_en = 1'b1;
    tick(1);
    trace_rd_en = 1'b0;
  endtask

  task automatic pulse_reset_a();
    rst_a = 1'b1;
    #1;
    rst_a = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr = '{32'h44, 32'h48, 32'h4C, 32'h60};
    exp_data = '{32'h2, 32'h3, 32'h4, 32'h77};

    rst_a = 1'b1; rst_b = 1'b1;
    mem_wen = 1'b0; mem_addr = '0; mem_din = '0; trace_rd_en = 1'b0;
    #3;
    check("rst_valid",   64'(a_valid),   64'(0));
    check("rst_count",   64'(a_count),   64'(0));
    check("rst_cc",      64'(a_cc),      64'(0));
    check("rst_ovf",     64'(a_ovf),     64'(0));
    check("rst_drop",    64'(a_drop),    64'(0));
    check("rst_halted",  64'(a_halted),  64'(0));
    check("rst_timeout", 64'(a_timeout), 64'(0));
    check("rst_addr",    64'(a_addr),    64'(0));

    // Basic capture: writes at cycles 3 and 5.
    tick(1);
    rst_a = 1'b0;
    tick(3);
    check("cc_at_3", 64'(a_cc), 64'(3));
    wr(32'h10, 32'hA);
    check("lat_valid", 64'(a_valid), 64'(1));
    check("lat_count", 64'(a_count), 64'(1));
    tick(1);
    wr(32'h14, 32'hB);
    check("head0_addr",  64'(a_addr),  64'(32'h10));
    check("head0_data",  64'(a_data),  64'(32'hA));
    check("head0_cycle", 64'(a_cycle), 64'(3));
    check("two_count",   64'(a_count), 64'(2));
    pop();
    check("head1_addr",  64'(a_addr),  64'(32'h14));
    check("head1_data",  64'(a_data),  64'(32'hB));
    check("head1_cycle", 64'(a_cycle), 64'(5));
    pop();
    check("empty_valid", 64'(a_valid), 64'(0));
    check("empty_data",  64'(a_data),  64'(0));
    check("empty_cycle", 64'(a_cycle), 64'(0));
    pop();
    check("pop_empty_count", 64'(a_count), 64'(0));

    // Overflow: six writes into four slots, then push+pop while full.
    pulse_reset_a();
    for (int i = 0; i < 6; i++) wr(32'h40 + 32'(4 * i), 32'(i + 1));
    check("ovf_count", 64'(a_count), 64'(4));
    check("ovf_flag",  64'(a_ovf),   64'(1));
    check("ovf_drop",  64'(a_drop),  64'(2));
    check("ovf_head",  64'(a_addr),  64'(32'h40));
    check("ovf_cycle", 64'(a_cycle), 64'(0));
    mem_wen = 1'b1; mem_addr = 32'h60; mem_din = 32'h77; trace_rd_en = 1'b1;
    tick(1);
    mem_wen = 1'b0; trace_rd_en = 1'b0;
    check("pp_count", 64'(a_count), 64'(4));
    check("pp_drop",  64'(a_drop),  64'(2));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_addr", i), 64'(a_addr), 64'(exp_addr[i]));
      check($sformatf("drain%0d_data", i), 64'(a_data), 64'(exp_data[i]));
      pop();
    end
    check("drain_valid", 64'(a_valid), 64'(0));

    // Halt: the halt write is captured, later writes are ignored, cycle counter freezes.
    pulse_reset_a();
    check("rst2_ovf",  64'(a_ovf),  64'(0));
    check("rst2_drop", 64'(a_drop), 64'(0));
    tick(1);
    wr(32'h30, 32'h1);
    wr(HALT, 32'hDEAD);
    check("halt_flag",    64'(a_halted),  64'(1));
    check("halt_timeout", 64'(a_timeout), 64'(0));
    check("halt_cc",      64'(a_cc),      64'(3));
    wr(32'h20, 32'h5);
    tick(3);
    check("halt_cc_frozen", 64'(a_cc),    64'(3));
    check("halt_count",     64'(a_count), 64'(2));
    check("halt_drop",      64'(a_drop),  64'(0));
    check("halt_head0",     64'(a_addr),  64'(32'h30));
    pop();
    check("halt_head1_addr",  64'(a_addr),  64'(HALT));
    check("halt_head1_data",  64'(a_data),  64'(32'hDEAD));
    check("halt_head1_cycle", 64'(a_cycle), 64'(2));
    pop();
    check("halt_no_0x20", 64'(a_valid), 64'(0));

    // Address window (only active in the filter build), then async reset mid-run.
    pulse_reset_a();
    tick(1);
    wr(32'h80, 32'h11);
    wr(32'h104, 32'h22);
`ifdef TRACE_FILTER_EN
    check("filt_count", 64'(a_count), 64'(1));
    check("filt_head",  64'(a_addr),  64'(32'h104));
`else
    check("filt_count", 64'(a_count), 64'(2));
    check("filt_head",  64'(a_addr),  64'(32'h80));
`endif
    check("filt_drop", 64'(a_drop), 64'(0));
    wr(HALT, 32'h33);
    check("filt_halt", 64'(a_halted), 64'(1));
`ifdef TRACE_FILTER_EN
    check("filt_halt_count", 64'(a_count), 64'(2));
`else
    check("filt_halt_count", 64'(a_count), 64'(3));
`endif
    rst_a = 1'b1;
    #1;
    check("async_valid",  64'(a_valid),  64'(0));
    check("async_count",  64'(a_count),  64'(0));
    check("async_halted", 64'(a_halted), 64'(0));
    check("async_cc",     64'(a_cc),     64'(0));
    check("async_addr",   64'(a_addr),   64'(0));
    rst_a = 1'b0;

    // Timeout after 8 RUN cycles; writes afterwards are ignored.
    tick(1);
    rst_b = 1'b0;
    tick(7);
    check("to_cc7",     64'(b_cc),      64'(7));
    check("to_not_yet", 64'(b_timeout), 64'(0));
    tick(1);
    check("to_flag",    64'(b_timeout), 64'(1));
    check("to_cc8",     64'(b_cc),      64'(8));
    check("to_halted",  64'(b_halted),  64'(0));
    wr(32'h50, 32'h1);
    tick(2);
    check("to_cc_frozen", 64'(b_cc),    64'(8));
    check("to_ignored",   64'(b_count), 64'(0));
    check("to_no_drop",   64'(b_drop),  64'(0));

    // Halt write on the timeout edge: halt wins and the write is captured.
    rst_b = 1'b1;
    #1;
    check("b_rst_timeout", 64'(b_timeout), 64'(0));
    check("b_rst_cc",      64'(b_cc),      64'(0));
    rst_b = 1'b0;
    tick(7);
    wr(HALT, 32'h99);
    check("tie_halted",  64'(b_halted),  64'(1));
    check("tie_timeout", 64'(b_timeout), 64'(0));
    check("tie_cc",      64'(b_cc),      64'(8));
    check("tie_count",   64'(b_count),   64'(1));
    check("tie_addr",    64'(b_addr),    64'(HALT));
    check("tie_cycle",   64'(b_cycle),   64'(7));
    tick(2);
    check("tie_still_halted", 64'(b_timeout), 64'(0));

    check("a_no_timeout", 64'(a_timeout), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
